// File: rtl/receive_ram_if.sv
`default_nettype none
// ============================================================================
//  Module      : receive_ram_if
//  Description : Bus bundle between the UART receiver / host and the 256x8
//                receive buffer. The master modport belongs to the side that
//                strobes bytes in and pops them out; the slave modport is the
//                buffer itself.
//  Revision    : 1.0 - initial release
// ============================================================================
interface receive_ram_if;
   // Write side, driven by the UART receiver
   logic       r_valid_i;
   logic [7:0] r_data_i;
   logic       r_ferr_i;

   // Host control
   logic       r_rd_en_i;
   logic       r_flush_i;
   logic       r_clr_ovf_i;

   // Buffer status and read data
   logic [7:0] r_data_o;
   logic       r_rd_valid_o;
   logic [8:0] r_count_o;
   logic       r_empty_o;
   logic       r_full_o;
   logic       r_overflow_o;
   logic [7:0] r_ferr_cnt_o;
   logic [8:0] r_lines_o;
   logic       r_line_ready_o;

   modport master (
      output r_valid_i, r_data_i, r_ferr_i,
      output r_rd_en_i, r_flush_i, r_clr_ovf_i,
      input  r_data_o, r_rd_valid_o, r_count_o, r_empty_o, r_full_o,
      input  r_overflow_o, r_ferr_cnt_o, r_lines_o, r_line_ready_o
   );

   modport slave (
      input  r_valid_i, r_data_i, r_ferr_i,
      input  r_rd_en_i, r_flush_i, r_clr_ovf_i,
      output r_data_o, r_rd_valid_o, r_count_o, r_empty_o, r_full_o,
      output r_overflow_o, r_ferr_cnt_o, r_lines_o, r_line_ready_o
   );
endinterface
`default_nettype wire

// File: rtl/receive_ram.sv
`default_nettype none
// ============================================================================
//  Module      : receive_ram
//  Description : 256x8 circular receive buffer for the UART receive path.
//                Bytes strobed in by the receiver are stored unless they carry
//                a framing error; the host pops them one at a time with a
//                single cycle of latency. Fill level, sticky overflow, framing
//                error count and the number of stored end-of-line bytes are
//                tracked so the host can wait for whole messages.
//  Revision    : 1.0 - initial release
// ============================================================================
module receive_ram #(
   parameter logic [7:0] TERM_BYTE = 8'h0A,
   parameter bit         EN_TERM   = 1'b1
) (
   input  wire             clk_i,
   input  wire             rst_i,
   receive_ram_if.slave    bus
);

   localparam logic [8:0] c_DEPTH    = 9'd256;
   localparam logic [7:0] c_FERR_MAX = 8'hFF;

   // Storage array: deliberately not reset, only pointers define validity
   logic [7:0] r_mem [256];

   logic [7:0] r_wptr;
   logic [7:0] r_rptr;
   logic [8:0] r_count;
   logic [8:0] r_lines;
   logic [7:0] r_rd_data;
   logic       r_rd_valid;
   logic       r_overflow;
   logic [7:0] r_ferr_cnt;

   logic       w_empty;
   logic       w_full;
   logic       w_pop_ok;
   logic       w_accept;
   logic       w_drop;
   logic       w_ferr_hit;
   logic [7:0] w_head_byte;
   logic       w_term_in;
   logic       w_term_out;

   // ------------------------------------------------------------------------
   // Status and transfer qualification
   // ------------------------------------------------------------------------
   // Empty/full come from the occupancy count: pointers are equal in both cases
   assign w_empty     = (r_count == 9'd0);
   assign w_full      = (r_count == c_DEPTH);
   assign w_head_byte = r_mem[r_rptr];

   // Flush wins over any push or pop in the same cycle. A pop on a full buffer
   // frees a slot, so a simultaneous push is accepted rather than dropped.
   assign w_pop_ok   = bus.r_rd_en_i & ~w_empty & ~bus.r_flush_i;
   assign w_accept   = bus.r_valid_i & ~bus.r_ferr_i & (~w_full | w_pop_ok)
                       & ~bus.r_flush_i;
   assign w_drop     = bus.r_valid_i & ~bus.r_ferr_i & w_full & ~w_pop_ok
                       & ~bus.r_flush_i;
   assign w_ferr_hit = bus.r_valid_i & bus.r_ferr_i;

   // Terminator detection on both sides; tied off when line counting is off
   assign w_term_in  = EN_TERM & w_accept & (bus.r_data_i == TERM_BYTE);
   assign w_term_out = EN_TERM & w_pop_ok & (w_head_byte == TERM_BYTE);

   // ------------------------------------------------------------------------
   // Sequential logic
   // ------------------------------------------------------------------------
   // Write accepted bytes into the array at the write pointer
   always_ff @(posedge clk_i) begin
      if (w_accept) begin
         r_mem[r_wptr] <= bus.r_data_i;
      end
   end

   // Pointer advance; both wrap naturally from 255 to 0
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_wptr <= 8'd0;
         r_rptr <= 8'd0;
      end else if (bus.r_flush_i) begin
         r_wptr <= 8'd0;
         r_rptr <= 8'd0;
      end else begin
         if (w_accept) r_wptr <= r_wptr + 8'd1;
         if (w_pop_ok) r_rptr <= r_rptr + 8'd1;
      end
   end

   // Occupancy: +1 on push only, -1 on pop only, unchanged otherwise
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_count <= 9'd0;
      end else if (bus.r_flush_i) begin
         r_count <= 9'd0;
      end else if (w_accept && !w_pop_ok) begin
         r_count <= r_count + 9'd1;
      end else if (w_pop_ok && !w_accept) begin
         r_count <= r_count - 9'd1;
      end
   end

   // Stored-terminator count; bounded by occupancy so it cannot wrap
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_lines <= 9'd0;
      end else if (bus.r_flush_i) begin
         r_lines <= 9'd0;
      end else if (w_term_in && !w_term_out) begin
         r_lines <= r_lines + 9'd1;
      end else if (w_term_out && !w_term_in) begin
         r_lines <= r_lines - 9'd1;
      end
   end

   // Registered read data with a one-cycle valid pulse; data holds otherwise
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_rd_data  <= 8'd0;
         r_rd_valid <= 1'b0;
      end else begin
         r_rd_valid <= w_pop_ok;
         if (w_pop_ok) begin
            r_rd_data <= w_head_byte;
         end
      end
   end

   // Sticky overflow; a new drop beats a same-cycle clear
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_overflow <= 1'b0;
      end else if (w_drop) begin
         r_overflow <= 1'b1;
      end else if (bus.r_clr_ovf_i) begin
         r_overflow <= 1'b0;
      end
   end

   // Framing-error byte counter, saturating at its maximum
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_ferr_cnt <= 8'd0;
      end else if (w_ferr_hit && (r_ferr_cnt != c_FERR_MAX)) begin
         r_ferr_cnt <= r_ferr_cnt + 8'd1;
      end
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign bus.r_data_o       = r_rd_data;
   assign bus.r_rd_valid_o   = r_rd_valid;
   assign bus.r_count_o      = r_count;
   assign bus.r_empty_o      = w_empty;
   assign bus.r_full_o       = w_full;
   assign bus.r_overflow_o   = r_overflow;
   assign bus.r_ferr_cnt_o   = r_ferr_cnt;
   assign bus.r_lines_o      = r_lines;
   assign bus.r_line_ready_o = (r_lines != 9'd0);

endmodule
`default_nettype wire

// File: tb/tb_receive_ram.sv
`default_nettype none
// ============================================================================
//  Module      : tb_receive_ram
//  Description : Directed self-checking bench for receive_ram.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_receive_ram;

   logic clk_i = 1'b0;
   logic rst_i = 1'b1;
   int   n_checks = 0;
   int   n_fail   = 0;

   receive_ram_if bus ();

   receive_ram #(
      .TERM_BYTE (8'h0A),
      .EN_TERM   (1'b1)
   ) dut (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .bus   (bus)
   );

   always #5 clk_i = ~clk_i;

   // Advance one rising edge and settle 1ns past it
   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic push(input logic [7:0] b, input logic fe);
      bus.r_valid_i = 1'b1;
      bus.r_data_i  = b;
      bus.r_ferr_i  = fe;
      tick();
      bus.r_valid_i = 1'b0;
      bus.r_ferr_i  = 1'b0;
   endtask

   task automatic test_reset();
      bus.r_valid_i   = 1'b0;
      bus.r_data_i    = 8'h00;
      bus.r_ferr_i    = 1'b0;
      bus.r_rd_en_i   = 1'b0;
      bus.r_flush_i   = 1'b0;
      bus.r_clr_ovf_i = 1'b0;
      rst_i = 1'b1;
      tick();
      tick();
      rst_i = 1'b0;
      tick();
      n_checks++;
      if (bus.r_count_o !== 9'd0 || bus.r_empty_o !== 1'b1 || bus.r_full_o !== 1'b0 ||
          bus.r_data_o !== 8'h00 || bus.r_rd_valid_o !== 1'b0 || bus.r_overflow_o !== 1'b0 ||
          bus.r_ferr_cnt_o !== 8'h00 || bus.r_lines_o !== 9'd0 || bus.r_line_ready_o !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_state: count=%0d empty=%b full=%b data=%h vld=%b ovf=%b ferr=%0d lines=%0d rdy=%b, required 0 1 0 00 0 0 0 0 0",
                  bus.r_count_o, bus.r_empty_o, bus.r_full_o, bus.r_data_o, bus.r_rd_valid_o,
                  bus.r_overflow_o, bus.r_ferr_cnt_o, bus.r_lines_o, bus.r_line_ready_o);
      end
   endtask

   task automatic test_basic();
      logic [7:0] exp_b [3];
      exp_b[0] = 8'h41; exp_b[1] = 8'h42; exp_b[2] = 8'h0A;
      for (int i = 0; i < 3; i++) push(exp_b[i], 1'b0);
      n_checks++;
      if (bus.r_count_o !== 9'd3 || bus.r_lines_o !== 9'd1 || bus.r_line_ready_o !== 1'b1) begin
         n_fail++;
         $display("FAIL basic_fill: count=%0d lines=%0d rdy=%b, required 3 1 1",
                  bus.r_count_o, bus.r_lines_o, bus.r_line_ready_o);
      end
      for (int i = 0; i < 3; i++) begin
         bus.r_rd_en_i = 1'b1;
         tick();
         bus.r_rd_en_i = 1'b0;
         n_checks++;
         if (bus.r_rd_valid_o !== 1'b1 || bus.r_data_o !== exp_b[i]) begin
            n_fail++;
            $display("FAIL basic_pop%0d: vld=%b data=%h, required 1 %h",
                     i, bus.r_rd_valid_o, bus.r_data_o, exp_b[i]);
         end
         n_checks++;
         if (bus.r_lines_o !== ((i == 2) ? 9'd0 : 9'd1)) begin
            n_fail++;
            $display("FAIL basic_lines%0d: lines=%0d, required %0d",
                     i, bus.r_lines_o, (i == 2) ? 0 : 1);
         end
         tick();
         n_checks++;
         if (bus.r_rd_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_pulse%0d: vld=%b, required 0", i, bus.r_rd_valid_o);
         end
      end
      n_checks++;
      if (bus.r_empty_o !== 1'b1 || bus.r_count_o !== 9'd0) begin
         n_fail++;
         $display("FAIL basic_empty: empty=%b count=%0d, required 1 0", bus.r_empty_o, bus.r_count_o);
      end
   endtask

   task automatic test_full_overflow();
      int bad = 0;
      for (int i = 0; i < 256; i++) push(8'(i), 1'b0);
      n_checks++;
      if (bus.r_full_o !== 1'b1 || bus.r_count_o !== 9'd256 || bus.r_lines_o !== 9'd1) begin
         n_fail++;
         $display("FAIL full_level: full=%b count=%0d lines=%0d, required 1 256 1",
                  bus.r_full_o, bus.r_count_o, bus.r_lines_o);
      end
      push(8'hAA, 1'b0);
      n_checks++;
      if (bus.r_overflow_o !== 1'b1 || bus.r_count_o !== 9'd256) begin
         n_fail++;
         $display("FAIL full_drop: ovf=%b count=%0d, required 1 256", bus.r_overflow_o, bus.r_count_o);
      end
      bus.r_rd_en_i = 1'b1;
      for (int i = 0; i < 256; i++) begin
         tick();
         n_checks++;
         if (bus.r_rd_valid_o !== 1'b1 || bus.r_data_o !== 8'(i)) begin
            n_fail++;
            bad++;
            if (bad < 5)
               $display("FAIL full_drain[%0d]: vld=%b data=%h, required 1 %h",
                        i, bus.r_rd_valid_o, bus.r_data_o, 8'(i));
         end
      end
      bus.r_rd_en_i = 1'b0;
      n_checks++;
      if (bus.r_empty_o !== 1'b1 || bus.r_lines_o !== 9'd0 || bus.r_overflow_o !== 1'b1) begin
         n_fail++;
         $display("FAIL full_drained: empty=%b lines=%0d ovf=%b, required 1 0 1",
                  bus.r_empty_o, bus.r_lines_o, bus.r_overflow_o);
      end
      bus.r_clr_ovf_i = 1'b1;
      tick();
      bus.r_clr_ovf_i = 1'b0;
      n_checks++;
      if (bus.r_overflow_o !== 1'b0) begin
         n_fail++;
         $display("FAIL ovf_clear: ovf=%b, required 0", bus.r_overflow_o);
      end
   endtask

   task automatic test_full_push_pop();
      int bad = 0;
      logic [7:0] exp_d;
      for (int i = 0; i < 256; i++) push(8'(i), 1'b0);
      bus.r_valid_i = 1'b1;
      bus.r_data_i  = 8'h55;
      bus.r_rd_en_i = 1'b1;
      tick();
      bus.r_valid_i = 1'b0;
      n_checks++;
      if (bus.r_rd_valid_o !== 1'b1 || bus.r_data_o !== 8'h00 || bus.r_count_o !== 9'd256 ||
          bus.r_overflow_o !== 1'b0) begin
         n_fail++;
         $display("FAIL fullpp_swap: vld=%b data=%h count=%0d ovf=%b, required 1 00 256 0",
                  bus.r_rd_valid_o, bus.r_data_o, bus.r_count_o, bus.r_overflow_o);
      end
      for (int i = 0; i < 256; i++) begin
         tick();
         exp_d = (i == 255) ? 8'h55 : 8'(i + 1);
         n_checks++;
         if (bus.r_rd_valid_o !== 1'b1 || bus.r_data_o !== exp_d) begin
            n_fail++;
            bad++;
            if (bad < 5)
               $display("FAIL fullpp_drain[%0d]: vld=%b data=%h, required 1 %h",
                        i, bus.r_rd_valid_o, bus.r_data_o, exp_d);
         end
      end
      bus.r_rd_en_i = 1'b0;
      n_checks++;
      if (bus.r_empty_o !== 1'b1 || bus.r_lines_o !== 9'd0) begin
         n_fail++;
         $display("FAIL fullpp_empty: empty=%b lines=%0d, required 1 0", bus.r_empty_o, bus.r_lines_o);
      end
   endtask

   task automatic test_ferr();
      for (int i = 0; i < 3; i++) push(8'h0A, 1'b1);
      push(8'h77, 1'b0);
      n_checks++;
      if (bus.r_count_o !== 9'd1 || bus.r_ferr_cnt_o !== 8'd3 || bus.r_lines_o !== 9'd0 ||
          bus.r_overflow_o !== 1'b0) begin
         n_fail++;
         $display("FAIL ferr_basic: count=%0d ferr=%0d lines=%0d ovf=%b, required 1 3 0 0",
                  bus.r_count_o, bus.r_ferr_cnt_o, bus.r_lines_o, bus.r_overflow_o);
      end
      bus.r_valid_i = 1'b1;
      bus.r_ferr_i  = 1'b1;
      bus.r_data_i  = 8'h10;
      for (int i = 0; i < 300; i++) tick();
      bus.r_valid_i = 1'b0;
      bus.r_ferr_i  = 1'b0;
      n_checks++;
      if (bus.r_ferr_cnt_o !== 8'd255 || bus.r_count_o !== 9'd1) begin
         n_fail++;
         $display("FAIL ferr_sat: ferr=%0d count=%0d, required 255 1", bus.r_ferr_cnt_o, bus.r_count_o);
      end
      bus.r_rd_en_i = 1'b1;
      tick();
      bus.r_rd_en_i = 1'b0;
      n_checks++;
      if (bus.r_data_o !== 8'h77 || bus.r_rd_valid_o !== 1'b1 || bus.r_empty_o !== 1'b1) begin
         n_fail++;
         $display("FAIL ferr_pop: data=%h vld=%b empty=%b, required 77 1 1",
                  bus.r_data_o, bus.r_rd_valid_o, bus.r_empty_o);
      end
   endtask

   task automatic test_empty_pop();
      bus.r_rd_en_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_checks++;
         if (bus.r_rd_valid_o !== 1'b0 || bus.r_data_o !== 8'h77) begin
            n_fail++;
            $display("FAIL empty_pop%0d: vld=%b data=%h, required 0 77",
                     i, bus.r_rd_valid_o, bus.r_data_o);
         end
      end
      bus.r_valid_i = 1'b1;
      bus.r_data_i  = 8'h33;
      tick();
      bus.r_valid_i = 1'b0;
      bus.r_rd_en_i = 1'b0;
      n_checks++;
      if (bus.r_count_o !== 9'd1 || bus.r_rd_valid_o !== 1'b0 || bus.r_data_o !== 8'h77) begin
         n_fail++;
         $display("FAIL empty_pushpop: count=%0d vld=%b data=%h, required 1 0 77",
                  bus.r_count_o, bus.r_rd_valid_o, bus.r_data_o);
      end
   endtask

   task automatic test_flush();
      logic [7:0] seq [10];
      seq[0] = 8'h01; seq[1] = 8'h0A; seq[2] = 8'h02; seq[3] = 8'h03; seq[4] = 8'h0A;
      seq[5] = 8'h04; seq[6] = 8'h05; seq[7] = 8'h06; seq[8] = 8'h07; seq[9] = 8'h08;
      for (int i = 0; i < 10; i++) push(seq[i], 1'b0);
      n_checks++;
      if (bus.r_count_o !== 9'd11 || bus.r_lines_o !== 9'd2) begin
         n_fail++;
         $display("FAIL flush_pre: count=%0d lines=%0d, required 11 2", bus.r_count_o, bus.r_lines_o);
      end
      // Push and pop alongside the flush must both be ignored
      bus.r_flush_i = 1'b1;
      bus.r_valid_i = 1'b1;
      bus.r_data_i  = 8'h0A;
      bus.r_rd_en_i = 1'b1;
      tick();
      bus.r_flush_i = 1'b0;
      bus.r_valid_i = 1'b0;
      bus.r_rd_en_i = 1'b0;
      n_checks++;
      if (bus.r_count_o !== 9'd0 || bus.r_lines_o !== 9'd0 || bus.r_empty_o !== 1'b1 ||
          bus.r_line_ready_o !== 1'b0 || bus.r_ferr_cnt_o !== 8'd255 ||
          bus.r_data_o !== 8'h77 || bus.r_rd_valid_o !== 1'b0) begin
         n_fail++;
         $display("FAIL flush_post: count=%0d lines=%0d empty=%b rdy=%b ferr=%0d data=%h vld=%b, required 0 0 1 0 255 77 0",
                  bus.r_count_o, bus.r_lines_o, bus.r_empty_o, bus.r_line_ready_o,
                  bus.r_ferr_cnt_o, bus.r_data_o, bus.r_rd_valid_o);
      end
   endtask

   task automatic test_async_reset();
      push(8'h0A, 1'b0);
      push(8'h0A, 1'b0);
      push(8'h5C, 1'b0);
      bus.r_rd_en_i = 1'b1;
      tick();
      bus.r_rd_en_i = 1'b0;
      n_checks++;
      if (bus.r_rd_valid_o !== 1'b1 || bus.r_data_o !== 8'h0A || bus.r_count_o !== 9'd2) begin
         n_fail++;
         $display("FAIL areset_pre: vld=%b data=%h count=%0d, required 1 0A 2",
                  bus.r_rd_valid_o, bus.r_data_o, bus.r_count_o);
      end
      // Assert reset mid-cycle, well before the next rising edge
      #3;
      rst_i = 1'b1;
      #1;
      n_checks++;
      if (bus.r_count_o !== 9'd0 || bus.r_empty_o !== 1'b1 || bus.r_full_o !== 1'b0 ||
          bus.r_data_o !== 8'h00 || bus.r_rd_valid_o !== 1'b0 || bus.r_overflow_o !== 1'b0 ||
          bus.r_ferr_cnt_o !== 8'h00 || bus.r_lines_o !== 9'd0 || bus.r_line_ready_o !== 1'b0) begin
         n_fail++;
         $display("FAIL areset_post: count=%0d empty=%b full=%b data=%h vld=%b ovf=%b ferr=%0d lines=%0d rdy=%b, required 0 1 0 00 0 0 0 0 0",
                  bus.r_count_o, bus.r_empty_o, bus.r_full_o, bus.r_data_o, bus.r_rd_valid_o,
                  bus.r_overflow_o, bus.r_ferr_cnt_o, bus.r_lines_o, bus.r_line_ready_o);
      end
      tick();
      rst_i = 1'b0;
      tick();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_full_overflow();
      test_full_push_pop();
      test_ferr();
      test_empty_pop();
      test_flush();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
